// File: rtl/hist_pkg.sv
// hist_pkg: shared state encoding and helpers for the projection histogram.
package hist_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE, READ} state_e;
   function automatic bit addr_fits(input int n, input int aw);
      return $clog2(n) <= aw;
   endfunction
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      return (v == (32'(1) << w) - 32'(1)) ? v : v + 32'(1);
   endfunction
endpackage

// File: rtl/hist_bin_array.sv
// hist_bin_array: saturating bin counters with an incremental peak tracker and async read port.
module hist_bin_array import hist_pkg::*; #(
   parameter int NBINS  = 256,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CNT_W-1:0]  rd_data,
   output logic [ADDR_W-1:0] peak_idx,
   output logic [CNT_W-1:0]  peak_cnt
);
   localparam int IW = $clog2(NBINS);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBINS - 1);
   logic [CNT_W-1:0]  cnt_q [NBINS];
   logic [CNT_W-1:0]  peak_cnt_q, new_cnt;
   logic [ADDR_W-1:0] peak_idx_q;
   logic              take;
   assign new_cnt = CNT_W'(sat_inc(32'(cnt_q[addr[IW-1:0]]), CNT_W));
   // ties go to the lower index so the peak matches a lowest-index argmax
   assign take = (new_cnt > peak_cnt_q) || (new_cnt == peak_cnt_q && addr < peak_idx_q);
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < NBINS; i++) cnt_q[i] <= '0;
         peak_cnt_q <= '0;
         peak_idx_q <= '0;
      end else if (inc) begin
         cnt_q[addr[IW-1:0]] <= new_cnt;
         if (take) begin
            peak_cnt_q <= new_cnt;
            peak_idx_q <= addr;
         end
      end
   end
   assign rd_data  = (rd_addr <= LAST) ? cnt_q[rd_addr[IW-1:0]] : '0;
   assign peak_idx = peak_idx_q;
   assign peak_cnt = peak_cnt_q;
endmodule

// File: rtl/projection_histogram.sv
// projection_histogram: per-column/per-row pixel counts with peak tracking and
// ready/valid readout of both histograms after each frame.
module projection_histogram import hist_pkg::*; #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pix_valid,
   input  logic [ADDR_W-1:0] pix_x,
   input  logic [ADDR_W-1:0] pix_y,
   input  logic              pix_data,
   input  logic              read_req,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_done,
   output logic [ADDR_W-1:0] out_idx,
   output logic [CNT_W-1:0]  x_hist,
   output logic [CNT_W-1:0]  y_hist,
   output logic              x_valid,
   output logic              y_valid,
   output logic              out_last,
   output logic [ADDR_W-1:0] peak_x,
   output logic [ADDR_W-1:0] peak_y,
   output logic [CNT_W-1:0]  peak_x_cnt,
   output logic [CNT_W-1:0]  peak_y_cnt
);
   localparam int NMAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
   localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(NMAX - 1);
   generate
      if (!addr_fits(NMAX, ADDR_W) || IMG_W < 2 || IMG_H < 2) begin : g_bad_params
         $error("projection_histogram: bad IMG_W/IMG_H/ADDR_W");
      end
   endgenerate
   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              frame_done_q;
   logic              acc, last_pix, rd;
   logic [CNT_W-1:0]  x_rd, y_rd;
   assign acc      = state_q == ACCUM && pix_valid && pix_x <= X_LAST && pix_y <= Y_LAST;
   assign last_pix = acc && pix_x == X_LAST && pix_y == Y_LAST;
   assign rd       = state_q == READ;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (start) begin
            state_q <= ACCUM;
            idx_q   <= '0;
         end else if (last_pix) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
         end else if (state_q == DONE && read_req) begin
            state_q <= READ;
            idx_q   <= '0;
         end else if (rd && out_ready) begin
            idx_q   <= (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
            state_q <= (idx_q == I_LAST) ? DONE : READ;
         end
      end
   end
   hist_bin_array #(.NBINS(IMG_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_cols (
      .clk(clk), .reset(reset), .clear(start), .inc(acc && pix_data), .addr(pix_x),
      .rd_addr(idx_q), .rd_data(x_rd), .peak_idx(peak_x), .peak_cnt(peak_x_cnt));
   hist_bin_array #(.NBINS(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rows (
      .clk(clk), .reset(reset), .clear(start), .inc(acc && pix_data), .addr(pix_y),
      .rd_addr(idx_q), .rd_data(y_rd), .peak_idx(peak_y), .peak_cnt(peak_y_cnt));
   assign busy       = state_q == ACCUM || rd;
   assign frame_done = frame_done_q;
   assign out_idx    = rd ? idx_q : '0;
   assign x_valid    = rd && idx_q <= X_LAST;
   assign y_valid    = rd && idx_q <= Y_LAST;
   assign out_last   = rd && idx_q == I_LAST;
   assign x_hist     = x_valid ? x_rd : '0;
   assign y_hist     = y_valid ? y_rd : '0;
endmodule

// File: tb/tb_projection_histogram.sv
// tb_projection_histogram: table-driven frames with a readout scoreboard on an 8x4
// instance, plus a 16x16 narrow-counter instance for saturation.
module tb_projection_histogram;
   localparam int W = 8, H = 4, AW = 4, CW = 4, N = 8;
   localparam int W2 = 16, CW2 = 3;
   logic clk = 1'b0, reset = 1'b1;
   logic start = 0, pix_valid = 0, pix_data = 0, read_req = 0, out_ready = 0;
   logic [AW-1:0] pix_x = '0, pix_y = '0;
   logic busy, frame_done, x_valid, y_valid, out_last;
   logic [AW-1:0] out_idx, peak_x, peak_y;
   logic [CW-1:0] x_hist, y_hist, peak_x_cnt, peak_y_cnt;
   logic b_start = 0, b_pix_valid = 0, b_pix_data = 0, b_read_req = 0, b_out_ready = 0;
   logic [3:0] b_pix_x = '0, b_pix_y = '0;
   logic b_busy, b_frame_done, b_x_valid, b_y_valid, b_out_last;
   logic [3:0] b_out_idx, b_peak_x, b_peak_y;
   logic [CW2-1:0] b_x_hist, b_y_hist, b_peak_x_cnt, b_peak_y_cnt;

   projection_histogram #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_x(pix_x),
      .pix_y(pix_y), .pix_data(pix_data), .read_req(read_req), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done), .out_idx(out_idx), .x_hist(x_hist),
      .y_hist(y_hist), .x_valid(x_valid), .y_valid(y_valid), .out_last(out_last),
      .peak_x(peak_x), .peak_y(peak_y), .peak_x_cnt(peak_x_cnt), .peak_y_cnt(peak_y_cnt));

   projection_histogram #(.IMG_W(W2), .IMG_H(W2), .ADDR_W(4), .CNT_W(CW2)) dut2 (
      .clk(clk), .reset(reset), .start(b_start), .pix_valid(b_pix_valid), .pix_x(b_pix_x),
      .pix_y(b_pix_y), .pix_data(b_pix_data), .read_req(b_read_req), .out_ready(b_out_ready),
      .busy(b_busy), .frame_done(b_frame_done), .out_idx(b_out_idx), .x_hist(b_x_hist),
      .y_hist(b_y_hist), .x_valid(b_x_valid), .y_valid(b_y_valid), .out_last(b_out_last),
      .peak_x(b_peak_x), .peak_y(b_peak_y), .peak_x_cnt(b_peak_x_cnt), .peak_y_cnt(b_peak_y_cnt));

   always #5 clk = ~clk;

   typedef struct {int mode; int px; int pxc; int py; int pyc;} vec_t;
   typedef struct {int idx; int xh; int yh; int xv; int yv; int last;} beat_t;
   vec_t  vecs[4];
   beat_t sb[$];
   int    q2[$];
   int    mcol[W], mrow[H];
   int    total = 0, bad = 0, fd_cnt = 0;
   int    rp[4] = '{1, 0, 0, 1};

   always @(negedge clk) if (frame_done) fd_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit pat(input int mode, input int x, input int y);
      case (mode)
         0: return 1'b1;
         1: return x == 5;
         2: return x >= y;
         3: return y == 2 || x == 6;
         default: return 1'b0;
      endcase
   endfunction

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model;
      for (int i = 0; i < W; i++) mcol[i] = 0;
      for (int i = 0; i < H; i++) mrow[i] = 0;
   endtask

   task automatic do_start;
      start = 1;
      cyc;
      start = 0;
      clear_model;
      chk("start busy", busy, 1);
      chk("start peak_x", peak_x, 0);
      chk("start peak_x_cnt", peak_x_cnt, 0);
      chk("start peak_y_cnt", peak_y_cnt, 0);
      chk("start x_valid", x_valid, 0);
      chk("start out_idx", out_idx, 0);
   endtask

   task automatic feed(input int mode, input int n);
      for (int k = 0; k < n; k++) begin
         pix_valid = 1;
         pix_x = AW'(k % W);
         pix_y = AW'(k / W);
         pix_data = pat(mode, k % W, k / W);
         if (pix_data) begin
            if (mcol[k % W] < 15) mcol[k % W]++;
            if (mrow[k / W] < 15) mrow[k / W]++;
         end
         cyc;
      end
      pix_valid = 0;
      pix_data = 0;
   endtask

   task automatic check_peaks(input vec_t v);
      chk("peak_x", peak_x, v.px);
      chk("peak_x_cnt", peak_x_cnt, v.pxc);
      chk("peak_y", peak_y, v.py);
      chk("peak_y_cnt", peak_y_cnt, v.pyc);
   endtask

   task automatic read_all;
      beat_t e;
      int k;
      for (int i = 0; i < N; i++) begin
         e.idx = i; e.xv = i < W; e.yv = i < H; e.last = i == N - 1;
         e.xh = e.xv ? mcol[i] : 0;
         e.yh = e.yv ? mrow[i] : 0;
         sb.push_back(e);
      end
      read_req = 1;
      cyc;
      read_req = 0;
      chk("read busy", busy, 1);
      k = 0;
      while (sb.size() > 0 && k < 100) begin
         out_ready = rp[k % 4] != 0;
         e = sb[0];
         chk("beat out_idx", out_idx, e.idx);
         chk("beat x_hist", x_hist, e.xh);
         chk("beat y_hist", y_hist, e.yh);
         chk("beat x_valid", x_valid, e.xv);
         chk("beat y_valid", y_valid, e.yv);
         chk("beat out_last", out_last, e.last);
         cyc;
         if (out_ready) void'(sb.pop_front());
         k++;
      end
      out_ready = 0;
      chk("read beats left", sb.size(), 0);
      sb.delete();
      chk("after read busy", busy, 0);
      chk("after read x_valid", x_valid, 0);
   endtask

   initial begin
      vecs[0] = '{0, 0, 4, 0, 8};
      vecs[1] = '{1, 5, 4, 0, 1};
      vecs[2] = '{2, 3, 4, 0, 8};
      vecs[3] = '{3, 6, 4, 2, 8};
      clear_model;
      cyc;
      cyc;
      chk("reset busy", busy, 0);
      chk("reset frame_done", frame_done, 0);
      chk("reset out_idx", out_idx, 0);
      chk("reset x_hist", x_hist, 0);
      chk("reset x_valid", x_valid, 0);
      chk("reset y_valid", y_valid, 0);
      chk("reset out_last", out_last, 0);
      chk("reset peak_x_cnt", peak_x_cnt, 0);
      reset = 0;
      cyc;
      for (int v = 0; v < 4; v++) begin
         do_start;
         fd_cnt = 0;
         feed(vecs[v].mode, W * H);
         chk("frame_done pulse", frame_done, 1);
         chk("done busy", busy, 0);
         check_peaks(vecs[v]);
         pix_valid = 1; pix_x = AW'(W - 1); pix_y = AW'(H - 1); pix_data = 1;
         cyc;
         pix_valid = 0; pix_data = 0;
         chk("frame_done one cycle", frame_done, 0);
         read_all;
         read_all;
         chk("frame_done count", fd_cnt, 1);
         check_peaks(vecs[v]);
      end
      do_start;
      fd_cnt = 0;
      pix_data = 1;
      pix_valid = 1; pix_x = 4'd9; pix_y = 4'd1; cyc;
      pix_x = 4'd8; pix_y = 4'd3; cyc;
      pix_x = 4'd2; pix_y = 4'd5; cyc;
      pix_x = 4'd15; pix_y = 4'd3; cyc;
      pix_valid = 0; pix_data = 0;
      read_req = 1; cyc; read_req = 0;
      chk("oor no frame end", fd_cnt, 0);
      chk("oor busy", busy, 1);
      chk("oor peak_x_cnt", peak_x_cnt, 0);
      chk("oor peak_y_cnt", peak_y_cnt, 0);
      chk("read_req in accum", x_valid, 0);
      feed(1, W * H);
      chk("oor frame_done", frame_done, 1);
      check_peaks(vecs[1]);
      read_all;
      read_req = 1; cyc; read_req = 0;
      out_ready = 1; cyc; cyc; out_ready = 0;
      chk("mid read out_idx", out_idx, 2);
      chk("mid read y_hist", y_hist, mrow[2]);
      start = 1; cyc; start = 0;
      clear_model;
      chk("abort read busy", busy, 1);
      chk("abort read out_idx", out_idx, 0);
      chk("abort read x_valid", x_valid, 0);
      chk("abort read y_valid", y_valid, 0);
      chk("abort read y_hist", y_hist, 0);
      chk("abort read out_last", out_last, 0);
      chk("abort read peak_x_cnt", peak_x_cnt, 0);
      chk("abort read peak_y_cnt", peak_y_cnt, 0);
      feed(0, 10);
      chk("partial peak_y_cnt", peak_y_cnt, 8);
      do_start;
      feed(1, W * H);
      check_peaks(vecs[1]);
      read_all;
      do_start;
      feed(0, 12);
      reset = 1; cyc; reset = 0;
      chk("mid accum reset busy", busy, 0);
      chk("mid accum reset peak_x_cnt", peak_x_cnt, 0);
      chk("mid accum reset peak_y_cnt", peak_y_cnt, 0);
      chk("mid accum reset peak_y", peak_y, 0);
      chk("mid accum reset frame_done", frame_done, 0);
      pix_valid = 1; pix_x = 4'd1; pix_y = 4'd1; pix_data = 1; cyc;
      pix_valid = 0; pix_data = 0;
      chk("idle pixel ignored", peak_x_cnt, 0);
      b_start = 1; cyc; b_start = 0;
      b_pix_data = 1;
      for (int k = 0; k < W2 * W2; k++) begin
         b_pix_valid = 1; b_pix_x = 4'(k % W2); b_pix_y = 4'(k / W2);
         cyc;
      end
      b_pix_valid = 0; b_pix_data = 0;
      chk("sat frame_done", b_frame_done, 1);
      chk("sat peak_y_cnt", b_peak_y_cnt, 7);
      chk("sat peak_x_cnt", b_peak_x_cnt, 7);
      chk("sat peak_y", b_peak_y, 0);
      chk("sat peak_x", b_peak_x, 0);
      for (int i = 0; i < W2; i++) q2.push_back(i);
      b_read_req = 1; cyc; b_read_req = 0;
      b_out_ready = 1;
      for (int k = 0; k < 40 && q2.size() > 0; k++) begin
         chk("sat beat idx", b_out_idx, q2[0]);
         chk("sat beat x_hist", b_x_hist, 7);
         chk("sat beat y_hist", b_y_hist, 7);
         chk("sat beat last", b_out_last, q2[0] == W2 - 1);
         void'(q2.pop_front());
         cyc;
      end
      b_out_ready = 0;
      chk("sat beats left", q2.size(), 0);
      chk("sat done busy", b_busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
